ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Parametrised execute stage. Single-cycle integer ALU plus RV32M/RV64M multiply/divide, implemented as a shared iterative radix-2 engine that computes one bit per cycle. It sits between the id/ex and ex/mem pipeline registers. It raises stallreq to hold the pipeline while a multi-cycle op is in flight, and drives the ex→id forwarding bus.

Parameters:
XLEN, 32, datapath width (32 or 64)
REG_AW, 5, register address width
OP_W, 5, width of op_i

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
flush_i  in  1  kill in-flight op (branch mispredict/exception)
op_i  in  OP_W  decoded operation code
reg1_i  in  XLEN  operand A (rs1)
reg2_i  in  XLEN  operand B (rs2/imm)
wd_i  in  REG_AW  destination register
wreg_i  in  1  write-enable request
wd_o  out  REG_AW  destination to ex/mem
wreg_o  out  1  write enable to ex/mem
wdata_o  out  XLEN  result to ex/mem
ex_wd_o  out  REG_AW  forwarding destination (equals wd_o)
ex_wreg_o  out  1  forwarding write enable (equals wreg_o)
ex_wdata_o  out  XLEN  forwarding data (equals wdata_o)
stallreq  out  1  hold IF/ID/EX stages

Behaviour:
- Reset (rst=1 at a clk edge): FSM→IDLE, all internal registers cleared. While rst=1 all outputs are 0. A reset mid-operation discards the op.
- op_i encoding:
  - 0 NOP: pass reg1_i through.
  - 1 ADD, 2 SUB, 3 SLL, 4 SRL, 5 SRA, 6 SLT, 7 SLTU, 8 AND, 9 OR, 10 XOR.
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - 19–31 illegal: wdata_o=0, wreg_o=0.
- ALU ops (0–10):
  - Combinational, zero latency, stallreq=0.
  - Shift amount is reg2_i[log2(XLEN)-1:0].
  - SLT/SLTU yield 0 or 1, zero-extended.
- M ops (11–18): FSM IDLE / BUSY / DONE.
  - IDLE with an M op present: stallreq=1 combinationally. Latch operands as magnitudes and latch sign flags. Next state is BUSY with counter=XLEN, or DONE on the fast path.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements; stallreq=1. When counter reaches 1 → DONE.
  - DONE: result registered and driven on wdata_o, including sign correction (negate if operand signs differ; REM takes the sign of the dividend). stallreq=0, so the pipeline advances this cycle. Next state is IDLE unconditionally.
  - Latency: an op first seen at cycle T has its result at T+XLEN+1. stallreq is high for XLEN+1 cycles (33 for XLEN=32).
- Fast path (IDLE→DONE, result at T+1, stallreq high 1 cycle):
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU = dividend.
  - Signed overflow (dividend = most-negative, divisor = −1): DIV = dividend; REM = 0.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits. Signedness is s×s, s×u and u×u respectively.
- wd_o/wreg_o follow wd_i/wreg_i in every state; the pipeline holds id/ex stable during the stall.
- While stallreq=1 and the result is not yet valid, wreg_o and ex_wreg_o are forced to 0. This prevents a stale forward.
- flush_i=1:
  - Takes priority over everything except rst.
  - FSM→IDLE on the next edge; stallreq=0 in the flush cycle; wreg_o=0.
  - No result is produced.
- Writes to x0 are not filtered here; the register file ignores them.

Test Plan:
- ADD reg1=0x7FFFFFFF, reg2=1, wd=5, wreg=1 → same cycle: wdata_o=0x80000000, wreg_o=1, stallreq=0.
- DIV reg1=−7 (0xFFFFFFF9), reg2=2 → stallreq high 33 cycles; at T+33 wdata_o=0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1).
- DIVU reg1=123, reg2=0 → stallreq high 1 cycle; at T+1 wdata_o=0xFFFFFFFF. REMU with the same operands → 123.
- DIV reg1=0x80000000, reg2=0xFFFFFFFF → at T+1 wdata_o=0x80000000. REM with the same operands → 0.
- MULH reg1=0x80000000, reg2=0x80000000 → wdata_o=0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MUL → 0x00000001.
- Start DIVU, assert flush_i at cycle T+10 → next cycle state IDLE, stallreq=0, wreg_o=0. Start DIVU again, assert rst at T+5 → all outputs 0. A following ADD completes in a single cycle.

Source files
------------

// File: rtl/ex_muldiv.sv
// Execute stage: zero-latency integer ALU plus an iterative radix-2 mul/div engine
// that stalls the pipeline while an M-extension operation is in flight.
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [XLEN-1:0]   reg1_i,
  input  logic [XLEN-1:0]   reg2_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [REG_AW-1:0] ex_wd_o,
  output logic              ex_wreg_o,
  output logic [XLEN-1:0]   ex_wdata_o,
  output logic              stallreq
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = OP_W'(0),
    OP_ADD    = OP_W'(1),
    OP_SUB    = OP_W'(2),
    OP_SLL    = OP_W'(3),
    OP_SRL    = OP_W'(4),
    OP_SRA    = OP_W'(5),
    OP_SLT    = OP_W'(6),
    OP_SLTU   = OP_W'(7),
    OP_AND    = OP_W'(8),
    OP_OR     = OP_W'(9),
    OP_XOR    = OP_W'(10),
    OP_MUL    = OP_W'(11),
    OP_MULH   = OP_W'(12),
    OP_MULHSU = OP_W'(13),
    OP_MULHU  = OP_W'(14),
    OP_DIV    = OP_W'(15),
    OP_DIVU   = OP_W'(16),
    OP_REM    = OP_W'(17),
    OP_REMU   = OP_W'(18)
  } op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  op_e             op;
  state_e          state;
  op_e             op_r;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, mag, res;
  logic            neg_q, neg_r, div_r;

  assign op = op_e'(op_i);

  // Operand decode for the M engine: magnitudes, sign flags and fast-path cases.
  logic            is_m, is_div, a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  always_comb begin
    is_m     = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_sgn    = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sa       = a_sgn & reg1_i[XLEN-1];
    sb       = b_sgn & reg2_i[XLEN-1];
    abs_a    = sa ? -reg1_i : reg1_i;
    abs_b    = sb ? -reg2_i : reg2_i;
    div_zero = is_div && (reg2_i == '0);
    div_ovf  = (op inside {OP_DIV, OP_REM}) && (reg1_i == MOST_NEG) && (reg2_i == '1);
    fast_res = '0;
    if (div_zero)
      fast_res = (op inside {OP_DIV, OP_DIVU}) ? '1 : reg1_i;
    else if (op == OP_DIV)
      fast_res = reg1_i;
  end

  // One engine step. hi/lo hold {partial product} for mul, {remainder, quotient} for div.
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   nxt_hi, nxt_lo, fin_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, mag};
    if (div_r) begin
      if (!div_diff[XLEN+1]) begin
        nxt_hi = div_diff[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = div_sh[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod = {nxt_hi, nxt_lo};
    if (neg_q)
      prod = -prod;
    case (op_r)
      OP_MUL:                      fin_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fin_res = neg_q ? -nxt_lo : nxt_lo;
      default:                     fin_res = neg_r ? -nxt_hi : nxt_hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= OP_NOP;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      mag   <= '0;
      res   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div_r <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_m) begin
            op_r  <= op;
            div_r <= is_div;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            hi    <= '0;
            cnt   <= CNT_W'(XLEN);
            if (is_div) begin
              lo  <= abs_a;
              mag <= abs_b;
            end else begin
              lo  <= abs_b;
              mag <= abs_a;
            end
            if (div_zero || div_ovf) begin
              res   <= fast_res;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            res   <= fin_res;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu, wdata;
  logic            alu_ok, wreg, stall;

  assign shamt = reg2_i[SH_W-1:0];

  always_comb begin
    alu    = '0;
    alu_ok = 1'b1;
    case (op)
      OP_NOP:  alu = reg1_i;
      OP_ADD:  alu = reg1_i + reg2_i;
      OP_SUB:  alu = reg1_i - reg2_i;
      OP_SLL:  alu = reg1_i << shamt;
      OP_SRL:  alu = reg1_i >> shamt;
      OP_SRA:  alu = $signed(reg1_i) >>> shamt;
      OP_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: alu = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
      OP_AND:  alu = reg1_i & reg2_i;
      OP_OR:   alu = reg1_i | reg2_i;
      OP_XOR:  alu = reg1_i ^ reg2_i;
      default: alu_ok = 1'b0;
    endcase

    stall = 1'b0;
    wdata = '0;
    wreg  = 1'b0;
    if (is_m) begin
      if (state == DONE) begin
        wdata = res;
        wreg  = wreg_i;
      end else begin
        stall = 1'b1;
      end
    end else if (alu_ok) begin
      wdata = alu;
      wreg  = wreg_i;
    end
    if (flush_i) begin
      stall = 1'b0;
      wreg  = 1'b0;
    end
    if (rst) begin
      stall = 1'b0;
      wreg  = 1'b0;
      wdata = '0;
    end
  end

  assign wd_o       = rst ? '0 : wd_i;
  assign wreg_o     = wreg;
  assign wdata_o    = wdata;
  assign ex_wd_o    = wd_o;
  assign ex_wreg_o  = wreg;
  assign ex_wdata_o = wdata;
  assign stallreq   = stall;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised bench for ex_muldiv against a plain-arithmetic RV32IM result model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic [4:0]  op_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o, ex_wd_o;
  logic        wreg_o, ex_wreg_o, stallreq;
  logic [31:0] wdata_o, ex_wdata_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .REG_AW(5), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .op_i(op_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_wdata_o(ex_wdata_o),
    .stallreq(stallreq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one instruction and how many cycles it should stall.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr, output logic [31:0] d, output logic w, output int st);
    longint      p;
    logic [63:0] pb;
    int          sa, sb;
    logic        zero, ovf;
    sa   = $signed(a);
    sb   = $signed(b);
    zero = (b == 32'd0);
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    w    = wr;
    st   = 0;
    d    = 32'd0;
    case (op)
      5'd0:  d = a;
      5'd1:  d = a + b;
      5'd2:  d = a - b;
      5'd3:  d = a << b[4:0];
      5'd4:  d = a >> b[4:0];
      5'd5:  d = 32'(sa >>> b[4:0]);
      5'd6:  d = (sa < sb) ? 32'd1 : 32'd0;
      5'd7:  d = (a < b) ? 32'd1 : 32'd0;
      5'd8:  d = a & b;
      5'd9:  d = a | b;
      5'd10: d = a ^ b;
      5'd11, 5'd12, 5'd13, 5'd14: begin
        st = 33;
        if (op == 5'd14)      p = longint'(a) * longint'(b);
        else if (op == 5'd13) p = longint'(sa) * longint'(b);
        else                  p = longint'(sa) * longint'(sb);
        pb = p;
        d  = (op == 5'd11) ? pb[31:0] : pb[63:32];
      end
      5'd15: begin st = (zero || ovf) ? 1 : 33; d = zero ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb); end
      5'd16: begin st = zero ? 1 : 33; d = zero ? 32'hFFFF_FFFF : a / b; end
      5'd17: begin st = (zero || ovf) ? 1 : 33; d = zero ? a : ovf ? 32'd0 : 32'(sa % sb); end
      5'd18: begin st = zero ? 1 : 33; d = zero ? a : a % b; end
      default: begin d = 32'd0; w = 1'b0; end
    endcase
  endtask

  // Called just after a rising edge; returns just after the edge following the result cycle.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wr);
    logic [31:0] ed;
    logic        ew;
    int          est, stalls, bad_wr;
    model(op, a, b, wr, ed, ew, est);
    op_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    stalls = 0;
    bad_wr = 0;
    while (1) begin
      @(negedge clk);
      if (!stallreq) break;
      if (wreg_o || ex_wreg_o) bad_wr++;
      stalls++;
      if (stalls > 40) break;
      @(posedge clk); #1;
    end
    check({tag, ".stall"}, 64'(stalls), 64'(est));
    check({tag, ".stall_wreg"}, 64'(bad_wr), 64'd0);
    check({tag, ".wdata"}, 64'(wdata_o), 64'(ed));
    check({tag, ".wreg"}, 64'(wreg_o), 64'(ew));
    check({tag, ".wd"}, 64'(wd_o), 64'(wd));
    check({tag, ".fwd"}, {ex_wdata_o, 26'd0, ex_wreg_o, ex_wd_o}, {ed, 26'd0, ew, wd});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    op_i = 5'd1; reg1_i = 32'd5; reg2_i = 32'd6; wd_i = 5'd7; wreg_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.outs", {wdata_o, ex_wdata_o, 22'd0, wreg_o, ex_wreg_o, stallreq, wd_o, ex_wd_o},
          64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("add_ovf",  5'd1,  32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
    run_op("div_neg",  5'd15, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    run_op("rem_neg",  5'd17, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    run_op("divu_z",   5'd16, 32'd123, 32'd0, 5'd7, 1'b1);
    run_op("remu_z",   5'd18, 32'd123, 32'd0, 5'd7, 1'b1);
    run_op("div_ovf",  5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    run_op("rem_ovf",  5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    run_op("mulh_mn",  5'd12, 32'h8000_0000, 32'h8000_0000, 5'd9, 1'b1);
    run_op("mulhu_ff", 5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
    run_op("mul_ff",   5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
    run_op("mulhsu",   5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
    run_op("illegal",  5'd25, 32'd3, 32'd4, 5'd10, 1'b1);

    // Flush ten cycles into a DIVU; the engine must restart from scratch afterwards.
    op_i = 5'd16; reg1_i = 32'd1000; reg2_i = 32'd7; wd_i = 5'd11; wreg_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    check("flush.stall", 64'(stallreq), 64'd0);
    check("flush.wreg", 64'(wreg_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    run_op("divu_after_flush", 5'd16, 32'd1000, 32'd7, 5'd11, 1'b1);

    // Reset five cycles into a DIVU.
    op_i = 5'd16; reg1_i = 32'd999; reg2_i = 32'd9; wd_i = 5'd12; wreg_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("midreset.outs", {wdata_o, ex_wdata_o, 22'd0, wreg_o, ex_wreg_o, stallreq, wd_o, ex_wd_o},
          64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("add_after_rst", 5'd1, 32'd40, 32'd2, 5'd13, 1'b1);
    run_op("divu_after_rst", 5'd16, 32'd999, 32'd9, 5'd12, 1'b1);

    for (int i = 0; i < 200; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(11, 18)) : 5'($urandom_range(0, 31));
      run_op("rand", op, rand_operand(), rand_operand(), 5'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
